// File: rtl/mem_arbiter.sv
// mem_arbiter: sole owner of the byte-wide RAM/IO port. It serializes 1/2/4-byte
//   accesses for three requesters (committed stores > loads > instruction fetch)
//   and returns a one-cycle done pulse to the winner.
// Latency: read of N bytes -> done pulse in the cycle after edge N+1 past the grant;
//   write of N bytes -> mem_wr for N cycles, st_done in the cycle after edge N.
// Backpressure: no queueing; losing requests stay pending at their source. Stores wait
//   while io_buffer_full is high. rdy=0 freezes every register.
// Ports:
//   clk, rst (sync, active-high), rdy (global enable), clear (flush of fetch/load traffic)
//   io_buffer_full           IO write FIFO full, blocks store grants
//   mem_din/mem_dout/mem_a/mem_wr   RAM/IO pins (read data arrives one cycle after mem_a)
//   fetch_req/fetch_addr -> fetch_done/fetch_inst        instruction fetch (always 4 bytes)
//   if_out_mem/out_mem_addr/out_mem_size/out_mem_signed -> if_get_mem/data_mem   loads
//   st_req/st_addr/st_data/st_size -> st_done            committed stores
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_done,
  output logic [31:0] fetch_inst,
  input  logic        if_out_mem,
  input  logic [31:0] out_mem_addr,
  input  logic [5:0]  out_mem_size,
  input  logic        out_mem_signed,
  output logic        if_get_mem,
  output logic [31:0] data_mem,
  input  logic        st_req,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [5:0]  st_size,
  output logic        st_done
);

  localparam int addrWidth = 32;
  localparam int dataWidth = 32;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic [1:0] {SRC_FETCH, SRC_LOAD, SRC_STORE} src_t;

  state_t                 state, state_n;
  src_t                   src_q, src_n;
  logic [2:0]             cnt, cnt_n;
  logic [2:0]             cnt_inc;
  logic [2:0]             len_q, len_n;
  logic                   sgn_q, sgn_n;
  logic [addrWidth-1:0]   addr_q, addr_n;
  logic [dataWidth-1:0]   wdata_q, wdata_n;
  logic [23:0]            rbuf_q, rbuf_n;   // bytes 0..2 of a read in flight
  logic [dataWidth-1:0]   rd_val;
  logic                   sx;

  logic [7:0]             mem_dout_n;
  logic [addrWidth-1:0]   mem_a_n;
  logic                   mem_wr_n;
  logic                   fetch_done_n;
  logic [dataWidth-1:0]   fetch_inst_n;
  logic                   if_get_mem_n;
  logic [dataWidth-1:0]   data_mem_n;
  logic                   st_done_n;

  // Access length in bytes; any encoding other than 1 or 2 means a full word.
  function automatic logic [2:0] size_len(input logic [5:0] sz);
    case (sz)
      6'd1:    return 3'd1;
      6'd2:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    case (i)
      2'd0:    return w[7:0];
      2'd1:    return w[15:8];
      2'd2:    return w[23:16];
      default: return w[31:24];
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      src_q      <= SRC_FETCH;
      cnt        <= '0;
      len_q      <= 3'd4;
      sgn_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rbuf_q     <= '0;
      mem_dout   <= '0;
      mem_a      <= '0;
      mem_wr     <= 1'b0;
      fetch_done <= 1'b0;
      fetch_inst <= '0;
      if_get_mem <= 1'b0;
      data_mem   <= '0;
      st_done    <= 1'b0;
    end else begin
      state      <= state_n;
      src_q      <= src_n;
      cnt        <= cnt_n;
      len_q      <= len_n;
      sgn_q      <= sgn_n;
      addr_q     <= addr_n;
      wdata_q    <= wdata_n;
      rbuf_q     <= rbuf_n;
      mem_dout   <= mem_dout_n;
      mem_a      <= mem_a_n;
      mem_wr     <= mem_wr_n;
      fetch_done <= fetch_done_n;
      fetch_inst <= fetch_inst_n;
      if_get_mem <= if_get_mem_n;
      data_mem   <= data_mem_n;
      st_done    <= st_done_n;
    end
  end

  always_comb begin
    state_n      = state;
    src_n        = src_q;
    cnt_n        = cnt;
    len_n        = len_q;
    sgn_n        = sgn_q;
    addr_n       = addr_q;
    wdata_n      = wdata_q;
    rbuf_n       = rbuf_q;
    mem_dout_n   = mem_dout;
    mem_a_n      = mem_a;
    mem_wr_n     = mem_wr;
    fetch_done_n = fetch_done;
    fetch_inst_n = fetch_inst;
    if_get_mem_n = if_get_mem;
    data_mem_n   = data_mem;
    st_done_n    = st_done;
    cnt_inc      = cnt + 3'd1;

    // The last byte of a read is taken straight from mem_din, so its MSB is the
    // sign bit for every length; a word read needs no extension at all.
    sx = sgn_q & mem_din[7];
    case (len_q)
      3'd1:    rd_val = {{24{sx}}, mem_din};
      3'd2:    rd_val = {{16{sx}}, mem_din, rbuf_q[7:0]};
      default: rd_val = {mem_din, rbuf_q[23:0]};
    endcase

    if (rdy) begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (st_req && !io_buffer_full) begin
            state_n    = WRITE;
            src_n      = SRC_STORE;
            addr_n     = st_addr;
            len_n      = size_len(st_size);
            wdata_n    = st_data;
            sgn_n      = 1'b0;
            mem_a_n    = st_addr;
            mem_dout_n = st_data[7:0];
            mem_wr_n   = 1'b1;
          end else if (!clear && if_out_mem) begin
            state_n  = READ;
            src_n    = SRC_LOAD;
            addr_n   = out_mem_addr;
            len_n    = size_len(out_mem_size);
            sgn_n    = out_mem_signed;
            mem_a_n  = out_mem_addr;
            mem_wr_n = 1'b0;
          end else if (!clear && fetch_req) begin
            state_n  = READ;
            src_n    = SRC_FETCH;
            addr_n   = fetch_addr;
            len_n    = 3'd4;
            sgn_n    = 1'b0;
            mem_a_n  = fetch_addr;
            mem_wr_n = 1'b0;
          end
        end

        READ: begin
          if (clear) begin
            // Flushed read: abandon it without any completion pulse.
            state_n = IDLE;
            cnt_n   = '0;
          end else begin
            // In cycle c (cnt == c) mem_din holds the byte addressed in cycle c-1.
            case (cnt)
              3'd1:    rbuf_n[7:0]   = mem_din;
              3'd2:    rbuf_n[15:8]  = mem_din;
              3'd3:    rbuf_n[23:16] = mem_din;
              default: ;
            endcase
            if (cnt == len_q) begin
              state_n = DONE;
              cnt_n   = '0;
              if (src_q == SRC_FETCH) begin
                fetch_inst_n = rd_val;
                fetch_done_n = 1'b1;
              end else begin
                data_mem_n   = rd_val;
                if_get_mem_n = 1'b1;
              end
            end else begin
              cnt_n = cnt_inc;
              // Hold the last address rather than touching a byte beyond the access.
              if (cnt_inc < len_q) begin
                mem_a_n = addr_q + {29'd0, cnt_inc};
              end
            end
          end
        end

        WRITE: begin
          // Committed stores are never flushed.
          if (cnt_inc == len_q) begin
            state_n   = DONE;
            cnt_n     = '0;
            mem_wr_n  = 1'b0;
            st_done_n = 1'b1;
          end else begin
            cnt_n      = cnt_inc;
            mem_a_n    = addr_q + {29'd0, cnt_inc};
            mem_dout_n = byte_of(wdata_q, cnt_inc[1:0]);
          end
        end

        default: begin
          // DONE: single cycle, no grant. Pulses drop on the way out, which also
          // covers a flush arriving while a fetch/load completion is showing.
          state_n      = IDLE;
          cnt_n        = '0;
          fetch_done_n = 1'b0;
          if_get_mem_n = 1'b0;
          st_done_n    = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        clear = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din = 8'h00;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        fetch_req = 1'b0;
  logic [31:0] fetch_addr = 32'h0;
  logic        fetch_done;
  logic [31:0] fetch_inst;
  logic        if_out_mem = 1'b0;
  logic [31:0] out_mem_addr = 32'h0;
  logic [5:0]  out_mem_size = 6'd0;
  logic        out_mem_signed = 1'b0;
  logic        if_get_mem;
  logic [31:0] data_mem;
  logic        st_req = 1'b0;
  logic [31:0] st_addr = 32'h0;
  logic [31:0] st_data = 32'h0;
  logic [5:0]  st_size = 6'd0;
  logic        st_done;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram     [0:262143];
  logic [7:0] ref_ram [0:262143];
  bit         seeded = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .io_buffer_full(io_buffer_full),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_done(fetch_done), .fetch_inst(fetch_inst),
    .if_out_mem(if_out_mem), .out_mem_addr(out_mem_addr), .out_mem_size(out_mem_size),
    .out_mem_signed(out_mem_signed), .if_get_mem(if_get_mem), .data_mem(data_mem),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_done(st_done)
  );

  // RAM/IO: mem_din in a cycle is the byte addressed in the previous cycle.
  initial begin
    wait (seeded);
    for (int i = 0; i < 262144; i++) ram[i] = ref_ram[i];
    forever begin
      @(posedge clk);
      mem_din <= ram[mem_a[17:0]];
      if (mem_wr === 1'b1) ram[mem_a[17:0]] = mem_dout;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  function automatic int n_of(input logic [5:0] sz);
    return (sz == 6'd1) ? 1 : (sz == 6'd2) ? 2 : 4;
  endfunction

  // Little-endian read of n bytes from the reference memory, then extension.
  function automatic logic [31:0] ref_read(input logic [31:0] a, input int n, input logic sg);
    logic [31:0] v;
    logic [31:0] t;
    v = '0;
    for (int i = 0; i < n; i++) begin
      t = a + 32'(i);
      v = v | ({24'd0, ref_ram[t[17:0]]} << (8 * i));
    end
    if (sg && n < 4 && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
    return v;
  endfunction

  task automatic drop_reqs();
    fetch_req  = 1'b0;
    if_out_mem = 1'b0;
    st_req     = 1'b0;
  endtask

  // Issues one request (0 store, 1 load, 2 fetch) from a negedge in IDLE and records
  // what the DUT does, cycle by cycle, counted from the grant edge.
  task automatic run_access(input int kind, input logic [31:0] a, input logic [5:0] sz,
                            input logic sg, input logic [31:0] d,
                            output int done_cyc, output int width, output logic [31:0] val,
                            output int wr_cnt, output logic [31:0] wr_bytes,
                            output logic [31:0] wr_first, output logic [31:0] wr_last);
    logic pulse;
    done_cyc = -1; width = 0; val = '0; wr_cnt = 0; wr_bytes = '0; wr_first = '0; wr_last = '0;
    case (kind)
      0:       begin st_req = 1'b1; st_addr = a; st_size = sz; st_data = d; end
      1:       begin if_out_mem = 1'b1; out_mem_addr = a; out_mem_size = sz; out_mem_signed = sg; end
      default: begin fetch_req = 1'b1; fetch_addr = a; end
    endcase
    @(posedge clk);
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      if (mem_wr === 1'b1) begin
        if (wr_cnt == 0) wr_first = mem_a;
        if (wr_cnt < 4) wr_bytes[8*wr_cnt +: 8] = mem_dout;
        wr_last = mem_a;
        wr_cnt++;
      end
      pulse = (kind == 0) ? st_done : (kind == 1) ? if_get_mem : fetch_done;
      if (pulse === 1'b1) begin
        if (done_cyc < 0) begin
          done_cyc = k;
          val = (kind == 2) ? fetch_inst : data_mem;
        end
        width++;
        drop_reqs();
      end
      if (done_cyc >= 0 && k >= done_cyc + 2) break;
    end
    drop_reqs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_a !== 32'h0) begin errors++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
    checks++;
    if ({mem_dout, mem_wr, fetch_done, if_get_mem, st_done} !== 12'h0) begin
      errors++; $display("FAIL reset_ctrl: got %h want 0", {mem_dout, mem_wr, fetch_done, if_get_mem, st_done});
    end
    checks++;
    if ({fetch_inst, data_mem} !== 64'h0) begin
      errors++; $display("FAIL reset_data: got %h want 0", {fetch_inst, data_mem});
    end
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    int dc, w, wc;
    logic [31:0] v, wb, wf, wl;
    run_access(2, 32'h100, 6'd4, 1'b0, 32'h0, dc, w, v, wc, wb, wf, wl);
    checks++;
    if (v !== 32'h00000513) begin errors++; $display("FAIL fetch_inst: got %h want 00000513", v); end
    checks++;
    if (dc !== 5) begin errors++; $display("FAIL fetch_latency: got %0d want 5", dc); end
    checks++;
    if (w !== 1) begin errors++; $display("FAIL fetch_pulse_width: got %0d want 1", w); end
  endtask

  task automatic test_signed_load();
    int dc, w, wc;
    logic [31:0] v, wb, wf, wl;
    run_access(1, 32'h200, 6'd1, 1'b1, 32'h0, dc, w, v, wc, wb, wf, wl);
    checks++;
    if (v !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_signed: got %h want ffffff80", v); end
    checks++;
    if (dc !== 2) begin errors++; $display("FAIL lb_latency: got %0d want 2", dc); end
    run_access(1, 32'h200, 6'd1, 1'b0, 32'h0, dc, w, v, wc, wb, wf, wl);
    checks++;
    if (v !== 32'h00000080) begin errors++; $display("FAIL lbu: got %h want 00000080", v); end
    // Unlisted size encoding behaves as a word access.
    run_access(1, 32'h100, 6'd3, 1'b1, 32'h0, dc, w, v, wc, wb, wf, wl);
    checks++;
    if (v !== 32'h00000513 || dc !== 5) begin
      errors++; $display("FAIL size3_as_word: got %h at %0d want 00000513 at 5", v, dc);
    end
  endtask

  task automatic test_priority();
    logic [31:0] wa [4];
    logic [7:0]  wd [4];
    int nw, sd, fd;
    logic [31:0] fi;
    nw = 0; sd = -1; fd = -1; fi = '0;
    for (int i = 0; i < 4; i++) begin wa[i] = '0; wd[i] = '0; end
    st_req = 1'b1; st_addr = 32'h300; st_data = 32'h1234; st_size = 6'd2;
    fetch_req = 1'b1; fetch_addr = 32'h100;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (mem_wr === 1'b1) begin
        if (nw < 4) begin wa[nw] = mem_a; wd[nw] = mem_dout; end
        nw++;
      end
      if (st_done === 1'b1 && sd < 0) begin sd = k; st_req = 1'b0; end
      if (fetch_done === 1'b1 && fd < 0) begin fd = k; fi = fetch_inst; fetch_req = 1'b0; end
      if (fd >= 0 && k >= fd + 2) break;
    end
    drop_reqs();
    checks++;
    if (nw !== 2) begin errors++; $display("FAIL prio_wr_cycles: got %0d want 2", nw); end
    checks++;
    if ({wa[0], wd[0]} !== {32'h300, 8'h34}) begin
      errors++; $display("FAIL prio_byte0: got %h/%h want 300/34", wa[0], wd[0]);
    end
    checks++;
    if ({wa[1], wd[1]} !== {32'h301, 8'h12}) begin
      errors++; $display("FAIL prio_byte1: got %h/%h want 301/12", wa[1], wd[1]);
    end
    checks++;
    if (sd !== 2) begin errors++; $display("FAIL prio_st_done: got %0d want 2", sd); end
    checks++;
    if (fd !== 9 || fi !== 32'h00000513) begin
      errors++; $display("FAIL prio_fetch_after: got %h at %0d want 00000513 at 9", fi, fd);
    end
  endtask

  task automatic test_clear_mid_load();
    int gets, sd;
    logic wr3, wr4;
    logic [31:0] a4;
    gets = 0; sd = -1; wr3 = 1'bx; wr4 = 1'bx; a4 = '0;
    if_out_mem = 1'b1; out_mem_addr = 32'h400; out_mem_size = 6'd4; out_mem_signed = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (if_get_mem === 1'b1) gets++;
      if (k == 2) begin
        clear = 1'b1; if_out_mem = 1'b0;
        st_req = 1'b1; st_addr = 32'h500; st_data = 32'hAB; st_size = 6'd1;
      end
      if (k == 3) begin clear = 1'b0; wr3 = mem_wr; end
      if (k == 4) begin wr4 = mem_wr; a4 = mem_a; end
      if (st_done === 1'b1 && sd < 0) begin sd = k; st_req = 1'b0; end
    end
    drop_reqs();
    checks++;
    if (gets !== 0) begin errors++; $display("FAIL clear_no_pulse: got %0d pulses want 0", gets); end
    checks++;
    if (wr3 !== 1'b0 || wr4 !== 1'b1 || a4 !== 32'h500) begin
      errors++; $display("FAIL clear_next_grant: got wr %b/%b a %h want 0/1 a 500", wr3, wr4, a4);
    end
    checks++;
    if (sd !== 5) begin errors++; $display("FAIL clear_store_done: got %0d want 5", sd); end
  endtask

  task automatic test_io_backpressure();
    int ld, wk, sd;
    logic [31:0] lv, wa;
    logic [7:0] wdb;
    ld = -1; wk = -1; sd = -1; lv = '0; wa = '0; wdb = '0;
    io_buffer_full = 1'b1;
    st_req = 1'b1; st_addr = 32'h30000; st_data = 32'h5A; st_size = 6'd1;
    if_out_mem = 1'b1; out_mem_addr = 32'h210; out_mem_size = 6'd1; out_mem_signed = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (if_get_mem === 1'b1 && ld < 0) begin ld = k; lv = data_mem; if_out_mem = 1'b0; end
      if (mem_wr === 1'b1 && wk < 0) begin wk = k; wa = mem_a; wdb = mem_dout; end
      if (st_done === 1'b1 && sd < 0) begin sd = k; st_req = 1'b0; end
      if (k == 6) io_buffer_full = 1'b0;
    end
    drop_reqs();
    checks++;
    if (ld !== 2 || lv !== ref_read(32'h210, 1, 1'b0)) begin
      errors++; $display("FAIL io_load_first: got %h at %0d want %h at 2", lv, ld, ref_read(32'h210, 1, 1'b0));
    end
    checks++;
    if (wk !== 7 || wa !== 32'h30000 || wdb !== 8'h5A) begin
      errors++; $display("FAIL io_store_start: got %h/%h at %0d want 30000/5a at 7", wa, wdb, wk);
    end
    checks++;
    if (sd !== 8) begin errors++; $display("FAIL io_store_done: got %0d want 8", sd); end
  endtask

  task automatic test_reset_mid_write();
    int sd;
    logic [109:0] outs;
    sd = -1; outs = '1;
    st_req = 1'b1; st_addr = 32'h600; st_data = 32'hDEADBEEF; st_size = 6'd4;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (st_done === 1'b1) sd = k;
      if (k == 1) begin rst = 1'b1; st_req = 1'b0; end
      if (k == 2) begin
        outs = {mem_a, mem_dout, mem_wr, fetch_done, if_get_mem, st_done, fetch_inst, data_mem[31:2]};
        rst = 1'b0;
      end
    end
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL rst_write_outputs: got %h want 0", outs); end
    checks++;
    if (sd !== -1) begin errors++; $display("FAIL rst_write_no_done: got pulse at %0d want none", sd); end
  endtask

  task automatic test_rdy_hold();
    int fd;
    logic [31:0] a3;
    fd = -1; a3 = '0;
    fetch_req = 1'b1; fetch_addr = 32'h100;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (fetch_done === 1'b1 && fd < 0) begin fd = k; fetch_req = 1'b0; end
      if (k == 1) rdy = 1'b0;
      if (k == 3) a3 = mem_a;
      if (k == 4) rdy = 1'b1;
    end
    drop_reqs();
    checks++;
    if (a3 !== 32'h101) begin errors++; $display("FAIL rdy_hold_addr: got %h want 101", a3); end
    checks++;
    if (fd !== 8) begin errors++; $display("FAIL rdy_hold_latency: got %0d want 8", fd); end
  endtask

  task automatic test_back_to_back();
    int p0, p1;
    p0 = -1; p1 = -1;
    fetch_req = 1'b1; fetch_addr = 32'h100;
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (fetch_done === 1'b1) begin
        if (p0 < 0) p0 = k; else if (p1 < 0) begin p1 = k; fetch_req = 1'b0; end
      end
    end
    drop_reqs();
    checks++;
    if (p1 - p0 !== 7) begin errors++; $display("FAIL b2b_fetch_spacing: got %0d want 7", p1 - p0); end
    p0 = -1; p1 = -1;
    st_req = 1'b1; st_addr = 32'h700; st_data = 32'hCAFEF00D; st_size = 6'd4;
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (st_done === 1'b1) begin
        if (p0 < 0) p0 = k; else if (p1 < 0) begin p1 = k; st_req = 1'b0; end
      end
    end
    drop_reqs();
    checks++;
    if (p1 - p0 !== 6) begin errors++; $display("FAIL b2b_store_spacing: got %0d want 6", p1 - p0); end
  endtask

  task automatic test_random();
    logic [5:0] sizes [6];
    int kind, n, dc, w, wc;
    logic [31:0] a, d, v, wb, wf, wl, mask, exp;
    logic [5:0] sz;
    logic sg;
    logic [31:0] t;
    sizes = '{6'd1, 6'd2, 6'd4, 6'd0, 6'd3, 6'd8};
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) a = 32'h1000 + 32'($urandom_range(0, 4095));
      else a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
      sz = sizes[$urandom_range(0, 5)];
      sg = 1'($urandom_range(0, 1));
      d = $urandom;
      n = (kind == 2) ? 4 : n_of(sz);
      mask = (n == 4) ? 32'hFFFFFFFF : ((32'h1 << (8 * n)) - 32'h1);
      run_access(kind, a, sz, sg, d, dc, w, v, wc, wb, wf, wl);
      checks++;
      if (w !== 1) begin errors++; $display("FAIL rand%0d pulse_width: got %0d want 1", it, w); end
      if (kind == 0) begin
        checks++;
        if (dc !== n || wc !== n) begin
          errors++; $display("FAIL rand%0d store_timing: got done %0d wr %0d want %0d/%0d", it, dc, wc, n, n);
        end
        checks++;
        if (wb !== (d & mask) || wf !== a || wl !== a + 32'(n - 1)) begin
          errors++; $display("FAIL rand%0d store_bytes: got %h %h..%h want %h %h..%h",
                             it, wb, wf, wl, d & mask, a, a + 32'(n - 1));
        end
        for (int i = 0; i < n; i++) begin
          t = a + 32'(i);
          ref_ram[t[17:0]] = d[8*i +: 8];
        end
      end else begin
        exp = ref_read(a, n, (kind == 1) ? sg : 1'b0);
        checks++;
        if (dc !== n + 1 || wc !== 0) begin
          errors++; $display("FAIL rand%0d read_timing: got done %0d wr %0d want %0d/0", it, dc, wc, n + 1);
        end
        checks++;
        if (v !== exp) begin errors++; $display("FAIL rand%0d read_value: got %h want %h", it, v, exp); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 262144; i++) ref_ram[i] = 8'($urandom);
    ref_ram[18'h100] = 8'h13;
    ref_ram[18'h101] = 8'h05;
    ref_ram[18'h102] = 8'h00;
    ref_ram[18'h103] = 8'h00;
    ref_ram[18'h200] = 8'h80;
    seeded = 1'b1;
    test_reset();
    test_fetch();
    test_signed_load();
    test_priority();
    test_clear_mid_load();
    test_io_backpressure();
    test_reset_mid_write();
    test_rdy_hold();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
